// File: rtl/sargantana_icache_pkg.sv
// Shared types and index helpers for the icache replacement logic.
package sargantana_icache_pkg;

    typedef enum logic [1:0] {
        REPL_LRU  = 2'd0,
        REPL_PLRU = 2'd1,
        REPL_RAND = 2'd2
    } repl_mode_e;

    function automatic int unsigned way_w(input int unsigned nways);
        return (nways > 1) ? $clog2(nways) : 1;
    endfunction

    function automatic int unsigned set_w(input int unsigned nsets);
        return (nsets > 1) ? $clog2(nsets) : 1;
    endfunction

    // Heap-ordered tree: node on the path to `way` at `depth` (root = depth 0).
    function automatic int unsigned plru_node(input int unsigned way, input int unsigned depth,
                                              input int unsigned wayw);
        return ((1 << depth) - 1) + (way >> (wayw - depth));
    endfunction

    // Branch taken at `depth` on the path to `way` (0 = left, 1 = right).
    function automatic logic plru_dir(input int unsigned way, input int unsigned depth,
                                      input int unsigned wayw);
        return 1'((way >> (wayw - 1 - depth)) & 1);
    endfunction

endpackage

// File: rtl/sargantana_icache_lfsr.sv
// Galois LFSR, right-shifting, advancing only when enabled.
module sargantana_icache_lfsr #(
    parameter int unsigned        P_WIDTH = 8,
    parameter logic [P_WIDTH-1:0] P_SEED  = P_WIDTH'(8'hA5),
    parameter logic [P_WIDTH-1:0] P_TAPS  = P_WIDTH'(8'hB8)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    output logic [P_WIDTH-1:0] value_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            value_o <= P_SEED;
        end else if (en_i) begin
            value_o <= {1'b0, value_o[P_WIDTH-1:1]} ^ (value_o[0] ? P_TAPS : '0);
        end
    end

endmodule

// File: rtl/sargantana_icache_repl_unit.sv
// Icache victim selection: per-set LRU / tree-PLRU / LFSR-random state,
// invalid-way priority, way locking and a one-cycle registered response.
module sargantana_icache_repl_unit
    import sargantana_icache_pkg::*;
#(
    parameter int unsigned P_NWAYS = 4,
    parameter int unsigned P_NSETS = 64,
    parameter repl_mode_e  P_MODE  = REPL_LRU,
    parameter logic [7:0]  P_SEED  = 8'hA5
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          lookup_valid_i,
    input  logic [set_w(P_NSETS)-1:0]     lookup_set_i,
    input  logic [P_NWAYS-1:0]            way_valid_i,
    input  logic [P_NWAYS-1:0]            way_lock_i,
    output logic                          victim_valid_o,
    output logic [way_w(P_NWAYS)-1:0]     victim_way_o,
    output logic                          victim_all_locked_o,
    input  logic                          update_i,
    input  logic [set_w(P_NSETS)-1:0]     upd_set_i,
    input  logic [way_w(P_NWAYS)-1:0]     upd_way_i,
    input  logic                          replace_i,
    input  logic [set_w(P_NSETS)-1:0]     rep_set_i,
    input  logic [way_w(P_NWAYS)-1:0]     rep_way_i
);

    localparam int unsigned WAY_W = way_w(P_NWAYS);
    localparam int unsigned NODES = P_NWAYS - 1;

    typedef logic [P_NWAYS-1:0][WAY_W-1:0] age_t;

    logic               all_locked;
    logic [P_NWAYS-1:0] eff_lock;
    logic               free_hit;
    logic [WAY_W-1:0]   free_way;
    logic [WAY_W-1:0]   policy_way;
    logic [WAY_W-1:0]   victim;
    logic               upd_en;

    assign all_locked = &way_lock_i;
    assign eff_lock   = all_locked ? '0 : way_lock_i;
    assign upd_en     = update_i && !(replace_i && (rep_set_i == upd_set_i));
    assign victim     = free_hit ? free_way : policy_way;

    // Lowest-index invalid and unlocked way wins before the policy is consulted.
    always_comb begin
        free_hit = 1'b0;
        free_way = '0;
        for (int w = int'(P_NWAYS) - 1; w >= 0; w--) begin
            if (!way_valid_i[w] && !eff_lock[w]) begin
                free_hit = 1'b1;
                free_way = WAY_W'(w);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            victim_valid_o      <= 1'b0;
            victim_way_o        <= '0;
            victim_all_locked_o <= 1'b0;
        end else begin
            victim_valid_o <= lookup_valid_i;
            if (lookup_valid_i) begin
                victim_way_o        <= victim;
                victim_all_locked_o <= all_locked;
            end
        end
    end

    function automatic age_t age_init();
        age_t a;
        for (int unsigned w = 0; w < P_NWAYS; w++) a[w] = WAY_W'(w);
        return a;
    endfunction

    function automatic age_t age_touch(input age_t a, input logic [WAY_W-1:0] t);
        age_t n;
        n = a;
        for (int unsigned w = 0; w < P_NWAYS; w++) begin
            if (a[w] < a[t]) n[w] = a[w] + WAY_W'(1);
        end
        n[t] = '0;
        return n;
    endfunction

    function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                    input logic [WAY_W-1:0] t);
        logic [NODES-1:0] n;
        n = bits;
        for (int unsigned w = 0; w < P_NWAYS; w++) begin
            if (t == WAY_W'(w)) begin
                for (int unsigned d = 0; d < WAY_W; d++)
                    n[plru_node(w, d, WAY_W)] = ~plru_dir(w, d, WAY_W);
            end
        end
        return n;
    endfunction

    function automatic logic [WAY_W-1:0] plru_leaf(input logic [NODES-1:0] bits);
        logic [WAY_W-1:0] leaf;
        logic             hit;
        leaf = '0;
        for (int unsigned w = 0; w < P_NWAYS; w++) begin
            hit = 1'b1;
            for (int unsigned d = 0; d < WAY_W; d++)
                if (bits[plru_node(w, d, WAY_W)] != plru_dir(w, d, WAY_W)) hit = 1'b0;
            if (hit) leaf = WAY_W'(w);
        end
        return leaf;
    endfunction

    if (P_MODE == REPL_LRU) begin : g_lru
        localparam logic [7:0] UNUSED_SEED = P_SEED;
        age_t age_q [P_NSETS];
        age_t cur;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int unsigned s = 0; s < P_NSETS; s++) age_q[s] <= age_init();
            end else if (flush_i) begin
                for (int unsigned s = 0; s < P_NSETS; s++) age_q[s] <= age_init();
            end else begin
                if (upd_en)    age_q[upd_set_i] <= age_touch(age_q[upd_set_i], upd_way_i);
                if (replace_i) age_q[rep_set_i] <= age_touch(age_q[rep_set_i], rep_way_i);
            end
        end

        // Oldest unlocked way; strict compare keeps the lowest index on ties.
        always_comb begin
            logic             found;
            logic [WAY_W-1:0] best;
            cur        = age_q[lookup_set_i];
            found      = 1'b0;
            best       = '0;
            policy_way = '0;
            for (int unsigned w = 0; w < P_NWAYS; w++) begin
                if (!eff_lock[w] && (!found || cur[w] > best)) begin
                    found      = 1'b1;
                    best       = cur[w];
                    policy_way = WAY_W'(w);
                end
            end
        end
    end else if (P_MODE == REPL_PLRU) begin : g_plru
        localparam logic [7:0] UNUSED_SEED = P_SEED;
        logic [NODES-1:0] plru_q [P_NSETS];
        logic [WAY_W-1:0] leaf;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int unsigned s = 0; s < P_NSETS; s++) plru_q[s] <= '0;
            end else if (flush_i) begin
                for (int unsigned s = 0; s < P_NSETS; s++) plru_q[s] <= '0;
            end else begin
                if (upd_en)    plru_q[upd_set_i] <= plru_touch(plru_q[upd_set_i], upd_way_i);
                if (replace_i) plru_q[rep_set_i] <= plru_touch(plru_q[rep_set_i], rep_way_i);
            end
        end

        assign leaf = plru_leaf(plru_q[lookup_set_i]);

        // A locked leaf falls back to the lowest-index unlocked way.
        always_comb begin
            policy_way = leaf;
            if (eff_lock[leaf]) begin
                for (int w = int'(P_NWAYS) - 1; w >= 0; w--)
                    if (!eff_lock[w]) policy_way = WAY_W'(w);
            end
        end
    end else begin : g_rand
        logic [7:0]       lfsr_val;
        logic [WAY_W-1:0] start;
        logic             unused_rand;

        sargantana_icache_lfsr #(
            .P_WIDTH (8),
            .P_SEED  (P_SEED)
        ) u_lfsr (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .en_i    (lookup_valid_i),
            .value_o (lfsr_val)
        );

        assign start       = lfsr_val[WAY_W-1:0];
        assign unused_rand = ^{flush_i, update_i, upd_set_i, upd_way_i,
                               replace_i, rep_set_i, rep_way_i, lfsr_val[7:WAY_W]};

        // First unlocked way scanning upward from the LFSR draw, wrapping.
        always_comb begin
            logic [WAY_W-1:0] idx;
            policy_way = start;
            for (int k = int'(P_NWAYS) - 1; k >= 0; k--) begin
                idx = start + WAY_W'(k);
                if (!eff_lock[idx]) policy_way = idx;
            end
        end
    end

endmodule

// File: tb/tb_sargantana_icache_repl_unit.sv
// Scoreboard bench: LRU, PLRU and RAND instances share touch/lookup buses.
module tb_sargantana_icache_repl_unit;
    import sargantana_icache_pkg::*;

    typedef struct {
        int         due;
        logic [1:0] way;
        logic       lk;
        logic       idle;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [2:0] lv = '0;
    logic [5:0] lset = '0;
    logic [3:0] wvalid = 4'hF;
    logic [3:0] wlock = 4'h0;
    logic       upd = 1'b0;
    logic [5:0] uset = '0;
    logic [1:0] uway = '0;
    logic       rep = 1'b0;
    logic [5:0] rset = '0;
    logic [1:0] rway = '0;

    logic       vv [3];
    logic [1:0] vw [3];
    logic       vl [3];

    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    exp_t       q [3][$];
    logic [7:0] m_lfsr = 8'hA5;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sargantana_icache_repl_unit #(.P_NWAYS(4), .P_NSETS(64), .P_MODE(REPL_LRU), .P_SEED(8'hA5)) u_lru (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .lookup_valid_i(lv[0]), .lookup_set_i(lset),
        .way_valid_i(wvalid), .way_lock_i(wlock), .victim_valid_o(vv[0]), .victim_way_o(vw[0]),
        .victim_all_locked_o(vl[0]), .update_i(upd), .upd_set_i(uset), .upd_way_i(uway),
        .replace_i(rep), .rep_set_i(rset), .rep_way_i(rway));

    sargantana_icache_repl_unit #(.P_NWAYS(4), .P_NSETS(64), .P_MODE(REPL_PLRU), .P_SEED(8'hA5)) u_plru (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .lookup_valid_i(lv[1]), .lookup_set_i(lset),
        .way_valid_i(wvalid), .way_lock_i(wlock), .victim_valid_o(vv[1]), .victim_way_o(vw[1]),
        .victim_all_locked_o(vl[1]), .update_i(upd), .upd_set_i(uset), .upd_way_i(uway),
        .replace_i(rep), .rep_set_i(rset), .rep_way_i(rway));

    sargantana_icache_repl_unit #(.P_NWAYS(4), .P_NSETS(64), .P_MODE(REPL_RAND), .P_SEED(8'hA5)) u_rand (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .lookup_valid_i(lv[2]), .lookup_set_i(lset),
        .way_valid_i(wvalid), .way_lock_i(wlock), .victim_valid_o(vv[2]), .victim_way_o(vw[2]),
        .victim_all_locked_o(vl[2]), .update_i(upd), .upd_set_i(uset), .upd_way_i(uway),
        .replace_i(rep), .rep_set_i(rset), .rep_way_i(rway));

    // Monitor: pop an expectation on its due cycle, otherwise no strobe allowed.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (q[i].size() > 0 && q[i][0].due == cyc) begin
                e = q[i].pop_front();
                total++;
                if (e.idle) begin
                    if (vv[i] !== 1'b0 || vw[i] !== 2'd0 || vl[i] !== 1'b0) begin
                        bad++;
                        $display("FAIL %s: got valid=%0b way=%0d all_locked=%0b, want valid=0 way=0 all_locked=0",
                                 e.name, vv[i], vw[i], vl[i]);
                    end
                end else if (vv[i] !== 1'b1 || vw[i] !== e.way || vl[i] !== e.lk) begin
                    bad++;
                    $display("FAIL %s: got valid=%0b way=%0d all_locked=%0b, want valid=1 way=%0d all_locked=%0b",
                             e.name, vv[i], vw[i], vl[i], e.way, e.lk);
                end
            end else if (vv[i] !== 1'b0) begin
                total++;
                bad++;
                $display("FAIL stray_strobe inst=%0d: got valid=%0b, want valid=0", i, vv[i]);
            end
        end
    end

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
    endfunction

    function automatic logic [1:0] rand_exp(input logic [3:0] v, input logic [3:0] l, input logic [7:0] lf);
        logic [3:0] eff;
        logic [1:0] idx;
        eff = (l == 4'hF) ? 4'h0 : l;
        for (int w = 0; w < 4; w++) if (!v[w] && !eff[w]) return 2'(w);
        for (int k = 0; k < 4; k++) begin
            idx = lf[1:0] + 2'(k);
            if (!eff[idx]) return idx;
        end
        return 2'd0;
    endfunction

    task automatic push(input int i, input logic [1:0] w, input logic lk, input logic idle, input string nm);
        exp_t e;
        e.due = cyc + 1; e.way = w; e.lk = lk; e.idle = idle; e.name = nm;
        q[i].push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        lv = '0; upd = 1'b0; rep = 1'b0; flush = 1'b0; wvalid = 4'hF; wlock = 4'h0;
    endtask

    task automatic lk_lru(input logic [5:0] s, input logic [3:0] v, input logic [3:0] l,
                          input logic [1:0] w, input logic lk, input string nm);
        lv[0] = 1'b1; lset = s; wvalid = v; wlock = l;
        push(0, w, lk, 1'b0, nm);
    endtask

    task automatic lk_plru(input logic [5:0] s, input logic [3:0] v, input logic [3:0] l,
                           input logic [1:0] w, input logic lk, input string nm);
        lv[1] = 1'b1; lset = s; wvalid = v; wlock = l;
        push(1, w, lk, 1'b0, nm);
    endtask

    task automatic lk_rand(input logic [5:0] s, input logic [3:0] v, input logic [3:0] l, input string nm);
        lv[2] = 1'b1; lset = s; wvalid = v; wlock = l;
        push(2, rand_exp(v, l, m_lfsr), &l, 1'b0, nm);
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    task automatic touch_upd(input logic [5:0] s, input logic [1:0] w);
        upd = 1'b1; uset = s; uway = w;
    endtask

    task automatic touch_rep(input logic [5:0] s, input logic [1:0] w);
        rep = 1'b1; rset = s; rway = w;
    endtask

    initial begin
        logic [3:0] l;
        step(); step();
        for (int i = 0; i < 3; i++) push(i, 2'd0, 1'b0, 1'b1, "reset_outputs");
        step();
        rst = 1'b0;
        step();

        // Age ordering: touch 0..3 makes way 0 the oldest again.
        for (int w = 0; w < 4; w++) begin touch_upd(6'd3, 2'(w)); step(); end
        lk_lru(6'd3, 4'hF, 4'h0, 2'd0, 1'b0, "t1_lru_set3");
        lk_plru(6'd3, 4'hF, 4'h0, 2'd0, 1'b0, "t1_plru_set3");
        step();

        // Invalid-way priority, locks, all-locked.
        lk_lru(6'd10, 4'b1011, 4'h0, 2'd2, 1'b0, "t2_lru_invalid");
        lk_plru(6'd10, 4'b1011, 4'h0, 2'd2, 1'b0, "t2_plru_invalid");
        lk_rand(6'd10, 4'b1011, 4'h0, "t2_rand_invalid");
        step();
        lk_lru(6'd10, 4'b1011, 4'b0100, 2'd3, 1'b0, "t2_lru_invalid_locked");
        lk_plru(6'd10, 4'b1011, 4'b0100, 2'd0, 1'b0, "t2_plru_invalid_locked");
        lk_rand(6'd10, 4'b1011, 4'b0100, "t2_rand_invalid_locked");
        step();
        lk_lru(6'd10, 4'hF, 4'hF, 2'd3, 1'b1, "t3_lru_all_locked");
        lk_plru(6'd10, 4'hF, 4'hF, 2'd0, 1'b1, "t3_plru_all_locked");
        lk_rand(6'd10, 4'hF, 4'hF, "t3_rand_all_locked");
        step();
        lk_lru(6'd10, 4'b1101, 4'hF, 2'd1, 1'b1, "t3_lru_all_locked_invalid");
        step();
        lk_lru(6'd10, 4'hF, 4'b1000, 2'd2, 1'b0, "t3_lru_oldest_locked");
        lk_plru(6'd10, 4'hF, 4'b1000, 2'd0, 1'b0, "t3_plru_other_locked");
        step();
        lk_plru(6'd10, 4'hF, 4'b0001, 2'd1, 1'b0, "t3_plru_leaf_locked");
        step();

        // PLRU tree walk.
        touch_upd(6'd20, 2'd0); step();
        lk_plru(6'd20, 4'hF, 4'h0, 2'd2, 1'b0, "t4_plru_after_w0");
        step();
        touch_upd(6'd20, 2'd2); step();
        lk_plru(6'd20, 4'hF, 4'h0, 2'd1, 1'b0, "t4_plru_after_w2");
        step();

        // Same-cycle touch must not be forwarded into the lookup.
        lk_lru(6'd9, 4'hF, 4'h0, 2'd3, 1'b0, "no_forward");
        touch_upd(6'd9, 2'd3);
        step();
        lk_lru(6'd9, 4'hF, 4'h0, 2'd2, 1'b0, "touch_applied");
        step();

        // Replace and update on the same set: replace wins.
        touch_rep(6'd5, 2'd1); touch_upd(6'd5, 2'd2); step();
        lk_lru(6'd5, 4'hF, 4'b1000, 2'd2, 1'b0, "t5_lru_same_set_a");
        lk_plru(6'd5, 4'hF, 4'b1000, 2'd2, 1'b0, "t5_plru_same_set");
        step();
        lk_lru(6'd5, 4'hF, 4'b1100, 2'd0, 1'b0, "t5_lru_same_set_b");
        step();
        // Different sets: both applied.
        touch_rep(6'd6, 2'd3); touch_upd(6'd7, 2'd1); step();
        lk_lru(6'd6, 4'hF, 4'h0, 2'd2, 1'b0, "t5_lru_rep_set6");
        step();
        lk_lru(6'd7, 4'hF, 4'b1100, 2'd0, 1'b0, "t5_lru_upd_set7");
        step();
        lk_plru(6'd7, 4'hF, 4'h0, 2'd2, 1'b0, "t5_plru_upd_set7");
        step();

        // Flush restores reset ordering and beats a same-cycle touch.
        flush = 1'b1; touch_upd(6'd8, 2'd3); step();
        lk_lru(6'd3, 4'hF, 4'h0, 2'd3, 1'b0, "t6_flush_set3");
        lk_plru(6'd3, 4'hF, 4'h0, 2'd0, 1'b0, "t6_plru_flush_set3");
        step();
        lk_lru(6'd5, 4'hF, 4'h0, 2'd3, 1'b0, "t6_flush_set5");
        lk_plru(6'd20, 4'hF, 4'h0, 2'd0, 1'b0, "t6_plru_flush_set20");
        step();
        lk_lru(6'd6, 4'hF, 4'h0, 2'd3, 1'b0, "t6_flush_set6"); step();
        lk_lru(6'd7, 4'hF, 4'h0, 2'd3, 1'b0, "t6_flush_set7");
        lk_plru(6'd7, 4'hF, 4'h0, 2'd0, 1'b0, "t6_plru_flush_set7");
        step();
        lk_lru(6'd8, 4'hF, 4'h0, 2'd3, 1'b0, "t6_flush_beats_touch"); step();

        // Back-to-back random lookups across more than one LFSR period, with wrap-around locks.
        for (int i = 0; i < 260; i++) begin
            l = (i % 5 == 0) ? 4'b0011 : ((i % 7 == 0) ? 4'b1110 : 4'b0000);
            lk_rand(6'(i), 4'hF, l, "t6_rand_seq");
            step();
        end
        step();

        // Reset while a lookup is in flight: no strobe, outputs cleared.
        lv[0] = 1'b1; lset = 6'd9; wvalid = 4'hF; wlock = 4'h0;
        rst = 1'b1;
        m_lfsr = 8'hA5;
        for (int i = 0; i < 3; i++) push(i, 2'd0, 1'b0, 1'b1, "rst_mid_lookup");
        step();
        rst = 1'b0;
        step();
        lk_rand(6'd0, 4'hF, 4'h0, "rand_seed_after_rst");
        step();
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
